// File: rtl/cute_key_pkg.sv
// Shared types and helpers for the key sequencer.
// Holds the FSM state enum, the idle-key fill and the step-advance function.
package cute_key_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Widest step index needed for NSTEPS up to 256.
    localparam int STEP_MAX_W = 8;

    // Fill bit for the default idle key (all zeros).
    localparam bit KEY_IDLE_FILL = 1'b0;

    // Modulo-nsteps increment; also used by lock-insertion models.
    function automatic logic [STEP_MAX_W-1:0] next_step(
        input logic [STEP_MAX_W-1:0] step,
        input int                    nsteps
    );
        if (int'(step) >= nsteps - 1) begin
            return '0;
        end
        return step + 8'd1;
    endfunction

endpackage

// File: rtl/cute_key_sequencer_if.sv
// Configuration bus between the key store and the sequencer.
// master: cfg_we/cfg_addr/cfg_data out, cfg_err in; slave is the mirror.
interface cute_key_sequencer_if #(
    parameter int KEY_BITS = 2,
    parameter int CNT_W    = 1
) ();

    logic                cfg_we;
    logic [CNT_W-1:0]    cfg_addr;
    logic [KEY_BITS-1:0] cfg_data;
    logic                cfg_err;

    modport master (
        output cfg_we,
        output cfg_addr,
        output cfg_data,
        input  cfg_err
    );

    modport slave (
        input  cfg_we,
        input  cfg_addr,
        input  cfg_data,
        output cfg_err
    );

endinterface

// File: rtl/cute_key_table.sv
// NSTEPS x KEY_BITS key register file.
// Ports: clock, clr (sync clear, wins over write), we/waddr/wdata, raddr/rdata (comb).
module cute_key_table #(
    parameter int KEY_BITS = 2,
    parameter int NSTEPS   = 2,
    parameter int CNT_W    = $clog2(NSTEPS)
) (
    input  logic                clock,
    input  logic                clr,
    input  logic                we,
    input  logic [CNT_W-1:0]    waddr,
    input  logic [KEY_BITS-1:0] wdata,
    input  logic [CNT_W-1:0]    raddr,
    output logic [KEY_BITS-1:0] rdata
);

    logic [KEY_BITS-1:0] mem [NSTEPS];

    always_ff @(posedge clock) begin
        if (clr) begin
            for (int i = 0; i < NSTEPS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // raddr is the step counter, which never exceeds NSTEPS-1.
    assign rdata = mem[raddr];

endmodule

// File: rtl/cute_key_sequencer.sv
// Drives the per-cycle key of a locked core in lock-step with its count state.
// Ports: clock, reset, cfg (slave bus), start/stop/adv/sync, key_out, step_o, running, wrap.
module cute_key_sequencer
    import cute_key_pkg::*;
#(
    parameter int KEY_BITS = 2,
    parameter int NSTEPS   = 2,
    parameter int CNT_W    = $clog2(NSTEPS),
    parameter logic [KEY_BITS-1:0] KEY_IDLE = {KEY_BITS{KEY_IDLE_FILL}}
) (
    input  logic                clock,
    input  logic                reset,
    cute_key_sequencer_if.slave cfg,
    input  logic                start,
    input  logic                stop,
    input  logic                adv,
    input  logic                sync,
    output logic [KEY_BITS-1:0] key_out,
    output logic [CNT_W-1:0]    step_o,
    output logic                running,
    output logic                wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSTEPS - 1);

    state_t              state_q;
    logic [CNT_W-1:0]    step_q;
    logic [CNT_W-1:0]    step_nxt;
    logic                addr_ok;
    logic                tbl_we;
    logic                err_q;
    logic [KEY_BITS-1:0] tbl_key;

    // Only matters when NSTEPS is not a power of two.
    assign addr_ok = ({1'b0, cfg.cfg_addr} < (CNT_W + 1)'(NSTEPS));

    assign tbl_we = cfg.cfg_we && (state_q == ST_IDLE) && addr_ok;

    assign step_nxt = CNT_W'(next_step(STEP_MAX_W'(step_q), NSTEPS));

    cute_key_table #(
        .KEY_BITS (KEY_BITS),
        .NSTEPS   (NSTEPS),
        .CNT_W    (CNT_W)
    ) u_table (
        .clock (clock),
        .clr   (reset),
        .we    (tbl_we),
        .waddr (cfg.cfg_addr),
        .wdata (cfg.cfg_data),
        .raddr (step_q),
        .rdata (tbl_key)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            err_q   <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            err_q <= cfg.cfg_we && ((state_q == ST_RUN) || !addr_ok);
            wrap  <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state_q <= ST_RUN;
                        step_q  <= '0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                        step_q  <= '0;
                    end else if (start || sync) begin
                        step_q <= '0;
                    end else if (adv) begin
                        step_q <= step_nxt;
                        wrap   <= (step_q == LAST);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    step_q  <= '0;
                end
            endcase
        end
    end

    assign cfg.cfg_err = err_q;
    assign running     = (state_q == ST_RUN);
    assign step_o      = step_q;
    assign key_out     = running ? tbl_key : KEY_IDLE;

endmodule

// File: tb/tb_cute_key_sequencer.sv
// Directed bench for cute_key_sequencer with a scoreboard queue.
// Covers NSTEPS=2,3,4 instances plus a locked serial-adder core end-to-end.
module tb_cute_key_sequencer;

    logic clock;
    logic reset;
    logic start;
    logic stop;
    logic adv;
    logic sync;

    cute_key_sequencer_if #(.KEY_BITS(2), .CNT_W(1)) if2 ();
    cute_key_sequencer_if #(.KEY_BITS(2), .CNT_W(2)) if4 ();
    cute_key_sequencer_if #(.KEY_BITS(2), .CNT_W(2)) if3 ();

    logic [1:0] k2, k4, k3;
    logic [0:0] s2;
    logic [1:0] s4, s3;
    logic r2, r4, r3, w2, w4, w3;

    cute_key_sequencer #(.KEY_BITS(2), .NSTEPS(2)) d2 (
        .clock(clock), .reset(reset), .cfg(if2.slave),
        .start(start), .stop(stop), .adv(adv), .sync(sync),
        .key_out(k2), .step_o(s2), .running(r2), .wrap(w2)
    );

    cute_key_sequencer #(.KEY_BITS(2), .NSTEPS(4)) d4 (
        .clock(clock), .reset(reset), .cfg(if4.slave),
        .start(start), .stop(stop), .adv(adv), .sync(sync),
        .key_out(k4), .step_o(s4), .running(r4), .wrap(w4)
    );

    cute_key_sequencer #(.KEY_BITS(2), .NSTEPS(3)) d3 (
        .clock(clock), .reset(reset), .cfg(if3.slave),
        .start(start), .stop(stop), .adv(adv), .sync(sync),
        .key_out(k3), .step_o(s3), .running(r3), .wrap(w3)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int         dut;
        string      tag;
        logic [6:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [6:0] observe(input int d);
        case (d)
            2:       return {k2, 1'b0, s2, r2, w2, if2.cfg_err};
            4:       return {k4, s4, r4, w4, if4.cfg_err};
            default: return {k3, s3, r3, w3, if3.cfg_err};
        endcase
    endfunction

    // Expected {key, step, running, wrap, cfg_err} after the next edge.
    task automatic ex(input int d, input string tag,
                      input logic [1:0] k, input logic [1:0] s,
                      input logic r, input logic w, input logic e);
        exp_t x;
        x.dut = d;
        x.tag = tag;
        x.v   = {k, s, r, w, e};
        exp_q.push_back(x);
    endtask

    task automatic tick();
        exp_t       x;
        logic [6:0] obs;
        @(posedge clock);
        #1;
        while (exp_q.size() > 0) begin
            x   = exp_q.pop_front();
            obs = observe(x.dut);
            total++;
            assert (obs === x.v) else begin
                bad++;
                $error("FAIL %s: observed %h expected %h", x.tag, obs, x.v);
            end
        end
    endtask

    task automatic wr2(input logic a, input logic [1:0] dv);
        if2.cfg_we = 1'b1; if2.cfg_addr = a; if2.cfg_data = dv;
        ex(2, "wr2", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        if2.cfg_we = 1'b0;
    endtask

    task automatic wr4(input logic [1:0] a, input logic [1:0] dv);
        if4.cfg_we = 1'b1; if4.cfg_addr = a; if4.cfg_data = dv;
        tick();
        if4.cfg_we = 1'b0;
    endtask

    task automatic wr3(input logic [1:0] a, input logic [1:0] dv);
        if3.cfg_we = 1'b1; if3.cfg_addr = a; if3.cfg_data = dv;
        ex(3, "wr3", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        if3.cfg_we = 1'b0;
    endtask

    // Locked serial-adder core: its inputs are XORed with (key ^ correct key)
    // through a modulo-4 count that tracks the sequencer step.
    logic [1:0] kok [4] = '{2'b01, 2'b11, 2'b00, 2'b10};
    logic       line1, line2, core_clr;
    logic [1:0] cnt;
    logic       lk_c, lk_out, lk_ov;
    logic       e1, e2;

    assign e1 = line1 ^ k4[0] ^ kok[cnt][0];
    assign e2 = line2 ^ k4[1] ^ kok[cnt][1];

    always @(posedge clock) begin
        if (core_clr) begin
            cnt    <= 2'd0;
            lk_c   <= 1'b0;
            lk_out <= 1'b0;
            lk_ov  <= 1'b0;
        end else begin
            cnt    <= cnt + 2'd1;
            lk_out <= e1 ^ e2 ^ lk_c;
            lk_ov  <= (e1 & e2) | (lk_c & (e1 ^ e2));
            lk_c   <= (e1 & e2) | (lk_c & (e1 ^ e2));
        end
    end

    logic       g_c, g_out, g_ov;
    int         mism;
    logic [1:0] gold_q[$];

    task automatic e2e(input bit flipped);
        logic [1:0] want;
        line1 = 1'($urandom_range(0, 1));
        line2 = 1'($urandom_range(0, 1));
        g_out = line1 ^ line2 ^ g_c;
        g_ov  = (line1 & line2) | (g_c & (line1 ^ line2));
        g_c   = g_ov;
        gold_q.push_back({g_out, g_ov});
        @(posedge clock);
        #1;
        want = gold_q.pop_front();
        if (!flipped) begin
            total++;
            assert ({lk_out, lk_ov} === want) else begin
                bad++;
                $error("FAIL e2e: observed %b expected %b",
                       {lk_out, lk_ov}, want);
            end
        end else if ({lk_out, lk_ov} !== want) begin
            mism++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        adv = 1'b0; sync = 1'b0;
        line1 = 1'b0; line2 = 1'b0; core_clr = 1'b1;
        g_c = 1'b0; mism = 0;
        if2.cfg_we = 1'b0; if2.cfg_addr = '0; if2.cfg_data = '0;
        if3.cfg_we = 1'b0; if3.cfg_addr = '0; if3.cfg_data = '0;
        // Write during reset must be ignored.
        if4.cfg_we = 1'b1; if4.cfg_addr = '0; if4.cfg_data = 2'd3;
        ex(4, "rst4", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        ex(2, "rst2", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        ex(3, "rst3", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0; if4.cfg_we = 1'b0;
        ex(4, "rst_hold", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        start = 1'b1;
        ex(4, "rst_no_wr", 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        start = 1'b0; stop = 1'b1;
        ex(4, "stop0", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        stop = 1'b0;

        // NSTEPS=2, adv held.
        wr2(1'b0, 2'b10);
        wr2(1'b1, 2'b01);
        start = 1'b1; adv = 1'b1;
        ex(2, "run2_s", 2'b10, 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            ex(2, "run2", (i % 2 == 1) ? 2'b01 : 2'b10,
               2'(i % 2), 1'b1, (i % 2 == 0), 1'b0);
            tick();
        end
        adv = 1'b0; stop = 1'b1;
        ex(2, "stop2", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        stop = 1'b0;

        // NSTEPS=4: stall, realign, wrap, rejected write, start+stop.
        for (int i = 0; i < 4; i++) wr4(2'(i), 2'(i));
        start = 1'b1;
        ex(4, "st4", 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        adv = 1'b1; ex(4, "adv_a", 2'd1, 2'd1, 1'b1, 1'b0, 1'b0); tick();
        adv = 1'b0; ex(4, "hold_a", 2'd1, 2'd1, 1'b1, 1'b0, 1'b0); tick();
        adv = 1'b0; ex(4, "hold_b", 2'd1, 2'd1, 1'b1, 1'b0, 1'b0); tick();
        adv = 1'b1; ex(4, "adv_b", 2'd2, 2'd2, 1'b1, 1'b0, 1'b0); tick();
        sync = 1'b1;
        ex(4, "sync", 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        sync = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            ex(4, "wrap4", 2'(i % 4), 2'(i % 4), 1'b1, (i == 4), 1'b0);
            tick();
        end
        adv = 1'b0;
        if4.cfg_we = 1'b1; if4.cfg_addr = 2'd0; if4.cfg_data = 2'd3;
        ex(4, "err_run", 2'd0, 2'd0, 1'b1, 1'b0, 1'b1);
        tick();
        if4.cfg_we = 1'b0;
        ex(4, "err_clr", 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        adv = 1'b1;
        ex(4, "adv_c", 2'd1, 2'd1, 1'b1, 1'b0, 1'b0);
        tick();
        adv = 1'b0; start = 1'b1; stop = 1'b1;
        ex(4, "st_sp", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        start = 1'b0; stop = 1'b0;

        // NSTEPS=3: out-of-range address and wrap at 2.
        if3.cfg_we = 1'b1; if3.cfg_addr = 2'd3; if3.cfg_data = 2'd1;
        ex(3, "bad_addr", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        tick();
        if3.cfg_we = 1'b0;
        ex(3, "bad_clr", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        wr3(2'd0, 2'd1);
        wr3(2'd1, 2'd2);
        wr3(2'd2, 2'd3);
        start = 1'b1; adv = 1'b1;
        ex(3, "st3", 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            ex(3, "run3", 2'((i % 3) + 1), 2'(i % 3), 1'b1, (i == 3), 1'b0);
            tick();
        end
        adv = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;

        // Reset mid-run at step 2 clears the table.
        start = 1'b1; adv = 1'b1;
        ex(4, "mr_s0", 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        ex(4, "mr_s1", 2'd1, 2'd1, 1'b1, 1'b0, 1'b0); tick();
        ex(4, "mr_s2", 2'd2, 2'd2, 1'b1, 1'b0, 1'b0); tick();
        reset = 1'b1; adv = 1'b0;
        ex(4, "rst_mid", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0; start = 1'b1; adv = 1'b1;
        ex(4, "clr_s0", 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            ex(4, "clr_run", 2'd0, 2'(i), 1'b1, 1'b0, 1'b0);
            tick();
        end
        stop = 1'b1; adv = 1'b0;
        tick();
        stop = 1'b0;

        // End-to-end with the correct key.
        for (int i = 0; i < 4; i++) wr4(2'(i), kok[i]);
        start = 1'b1; core_clr = 1'b1; adv = 1'b1;
        ex(4, "e2e_st", kok[0], 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        start = 1'b0; core_clr = 1'b0; g_c = 1'b0;
        for (int i = 0; i < 200; i++) e2e(1'b0);

        // Same run with entry 0 corrupted must diverge.
        stop = 1'b1; adv = 1'b0;
        tick();
        stop = 1'b0;
        wr4(2'd0, kok[0] ^ 2'b01);
        start = 1'b1; core_clr = 1'b1; adv = 1'b1;
        tick();
        start = 1'b0; core_clr = 1'b0; g_c = 1'b0;
        for (int i = 0; i < 200; i++) e2e(1'b1);
        total++;
        assert (mism > 0) else begin
            bad++;
            $error("FAIL wrong_key: observed %0d mismatches expected >0", mism);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cute_key_sequencer.md
Name: cute_key_sequencer

Overview:
- Supplies the time-varying key to a structurally locked sequential core, such as a locked ITC99 netlist, whose per-cycle key mux is selected by an internal modulo-NSTEPS count state.
- Holds a programmable table of NSTEPS key words and drives keyinput[step] in lock-step with the core's count state.
- Sits between the secure key store / configuration bus and the locked core's keyinput pins.

Parameters:
- KEY_BITS, 2, width of one key word (number of keyinput pins on the locked core)
- NSTEPS, 2, number of key phases (modulus of the core's count state); legal range 2..256
- CNT_W, $clog2(NSTEPS), width of step index and config address
- KEY_IDLE, '0, value driven on key_out when not running

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  CNT_W  table entry to write
- cfg_data  in  KEY_BITS  key word to write
- cfg_err  out  1  one-cycle pulse: rejected write
- start  in  1  enter RUN with step 0
- stop  in  1  return to IDLE
- adv  in  1  core clock-enable; step advances only when 1
- sync  in  1  realign step to 0 while running
- key_out  out  KEY_BITS  key to the locked core's keyinput pins
- step_o  out  CNT_W  current step index
- running  out  1  1 in RUN
- wrap  out  1  one-cycle pulse when step goes NSTEPS-1 -> 0 via adv

Behaviour:
- Reset is synchronous and active-high. It sets state=IDLE, step=0, all table entries=0, cfg_err=0 and wrap=0. key_out=KEY_IDLE, step_o=0 and running=0 during and after reset.
- States are IDLE and RUN. Registered state and step; key_out is combinational from the registered state, step and table.
- key_out = table[step] in RUN, KEY_IDLE in IDLE. No added latency: key_out for the core's count c is present in the same cycle the core is in count c.
- IDLE -> RUN on start=1 and stop=0. Step=0 in the first RUN cycle.
- RUN -> IDLE on stop=1. Step is cleared to 0. key_out=KEY_IDLE in the next cycle.
- start while in RUN restarts at step 0. If start and stop are both high, stop wins.
- In RUN, with sync=1: step<=0 next cycle, regardless of adv. No wrap pulse.
- In RUN, with adv=1 and sync=0: step<=step+1, or 0 if step==NSTEPS-1. In the wrap case, wrap=1 for the following cycle.
- In RUN, with adv=0 and sync=0: step holds.
- Writes in IDLE with cfg_addr<NSTEPS: table[cfg_addr]<=cfg_data. The new value is visible on key_out only after start.
- cfg_err=1 for one cycle (the cycle after the strobe), with the table unchanged, if cfg_we=1 while in RUN or the write is in IDLE with cfg_addr>=NSTEPS (possible when NSTEPS is not a power of two).
- cfg_we is ignored in the same cycle as reset.
- Reset mid-RUN: the next cycle is IDLE with the table cleared. The sequencer must be reprogrammed.
- Step arithmetic is in CNT_W bits and never exceeds NSTEPS-1.

Decomposition:
- Shared package cute_key_pkg holds:
  - state enum {ST_IDLE, ST_RUN}
  - default KEY_IDLE
  - a function next_step(step, NSTEPS) shared with the lock-insertion testbench models
- One sub-module, cute_key_table: an NSTEPS x KEY_BITS register file with a synchronous write port, a synchronous clear and one combinational read port.
- The sequencer FSM, step counter and error logic stay in the top module.

Test Plan:
- Run with adv held: reset, then write table = {2'b10, 2'b01} with NSTEPS=2, then start, then adv=1 for 6 cycles -> key_out = 10, 01, 10, 01, 10, 01; wrap pulses after cycles 2, 4 and 6; step_o = 0, 1, 0, 1, ...
- Stall and realign: NSTEPS=4, table = {0, 1, 2, 3}, KEY_BITS=2, start, adv pattern 1, 0, 0, 1 -> key_out = 0, 1, 1, 1, 2; then sync=1 with adv=1 -> next key_out = 0 and no wrap pulse.
- Config rejection: cfg_we in RUN with addr 0, data 3 -> cfg_err pulses once and the table is unchanged. With NSTEPS=3 in IDLE, a write to addr 3 -> cfg_err pulses once.
- start and stop asserted together in RUN -> IDLE next cycle, key_out = KEY_IDLE, step_o = 0, running = 0.
- Reset mid-RUN at step 2 -> next cycle state IDLE, table all zero. A subsequent start with no writes -> key_out = 0 for every step.
- End-to-end: the sequencer drives a locked b01-class core with the correct table, against the unlocked golden model, for 200 random LINE1/LINE2 cycles -> OUTP_REG and OVERFLW_REG match every cycle. With table entry 0 flipped -> at least one mismatch.
